// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Index 0 is the hardwired-zero register, so writes to it are no-ops.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

  // Buffer occupancy: FORCE is HELD plus a pipeline stall request.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_hold_buffer.sv
// One-entry destination/value register holding an MDU result until the
// register file write port is free.
module wb_hold_buffer #(
  parameter int unsigned DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_pos,
  input  logic [DATA_W-1:0] load_value,
  output logic [ADDR_W-1:0] pos,
  output logic [DATA_W-1:0] value
);

  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [DATA_W-1:0] value_q, value_d;

  // Load wins over clear; the arbiter never asserts both together.
  always_comb begin
    pos_d   = pos_q;
    value_d = value_q;
    if (load) begin
      pos_d   = load_pos;
      value_d = load_value;
    end else if (clear) begin
      pos_d   = '0;
      value_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pos_q   <= '0;
      value_q <= '0;
    end else begin
      pos_q   <= pos_d;
      value_q <= value_d;
    end
  end

  assign pos   = pos_q;
  assign value = value_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the pipeline writeback stage
// (priority, combinational) and a buffered multi-cycle MDU result.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              pipe_we,
  input  logic [ADDR_W-1:0]                 pipe_pos,
  input  logic [DATA_W-1:0]                 pipe_value,
  input  logic                              mdu_valid,
  output logic                              mdu_ready,
  input  logic [ADDR_W-1:0]                 mdu_pos,
  input  logic [DATA_W-1:0]                 mdu_value,
  output logic [ADDR_W-1:0]                 wr_pos,
  output logic [DATA_W-1:0]                 wr_value,
  output logic                              stall_pipe,
  output logic                              pend_valid,
  output logic [ADDR_W-1:0]                 pend_pos,
  output logic                              drop_pulse,
  output logic                              protocol_err,
  output regfile_wb_arbiter_pkg::arb_state_e dbg_state
);

  import regfile_wb_arbiter_pkg::*;

  // MDU handshake: a result transfers on a rising clock edge where
  // mdu_valid && mdu_ready; mdu_ready does not depend on mdu_valid.
  // The pipeline has no handshake and must honour stall_pipe itself.

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              protocol_err_q, protocol_err_d;
  logic              pipe_eff;
  logic              mdu_take;
  logic              buf_load;
  logic              buf_clear;
  logic              grant;
  logic              drop;
  logic [3:0]        wait_inc;
  logic [ADDR_W-1:0] buf_pos;
  logic [DATA_W-1:0] buf_value;

  assign pipe_eff = pipe_we && (pipe_pos != ADDR_W'(ZERO_REG));
  assign mdu_take = mdu_valid && (state_q == ST_EMPTY);
  assign wait_inc = wait_cnt_q + 4'd1;

  wb_hold_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clock      (clock),
    .resetn     (resetn),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_pos   (mdu_pos),
    .load_value (mdu_value),
    .pos        (buf_pos),
    .value      (buf_value)
  );

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    protocol_err_d = protocol_err_q;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    grant          = 1'b0;
    drop           = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        // A result for r0 is accepted and simply never buffered.
        if (mdu_take && (mdu_pos != ADDR_W'(ZERO_REG))) begin
          buf_load   = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = ST_HELD;
        end
      end
      ST_HELD, ST_FORCE: begin
        if (!pipe_eff) begin
          grant      = 1'b1;
          buf_clear  = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = ST_EMPTY;
        end else if (pipe_pos == buf_pos) begin
          // Younger pipeline write to the same register makes ours stale.
          drop       = 1'b1;
          buf_clear  = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = ST_EMPTY;
        end else if (state_q == ST_HELD) begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= WAIT_LAST) begin
            state_d = ST_FORCE;
          end
        end else begin
          protocol_err_d = 1'b1;
        end
      end
      default: begin
        buf_clear  = 1'b1;
        wait_cnt_d = 4'd0;
        state_d    = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_EMPTY;
      wait_cnt_q     <= 4'd0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Pipe priority is stateless, so this path is live even in reset.
  always_comb begin
    wr_pos   = '0;
    wr_value = '0;
    if (pipe_eff) begin
      wr_pos   = pipe_pos;
      wr_value = pipe_value;
    end else if (grant) begin
      wr_pos   = buf_pos;
      wr_value = buf_value;
    end
  end

  assign mdu_ready    = (state_q == ST_EMPTY);
  assign stall_pipe   = (state_q == ST_FORCE);
  assign pend_valid   = (state_q != ST_EMPTY);
  assign pend_pos     = buf_pos;
  assign drop_pulse   = drop;
  assign protocol_err = protocol_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: cycle vector table, a reset
// mid-operation sequence and randomized pipeline-only traffic.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int EXP_W = 5 + 32 + 1 + 1 + 1 + 5 + 1 + 1;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_pos = '0;
  logic [31:0] pipe_value = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_pos = '0;
  logic [31:0] mdu_value = '0;
  logic [4:0]  wr_pos;
  logic [31:0] wr_value;
  logic        stall_pipe, pend_valid, drop_pulse, protocol_err;
  logic [4:0]  pend_pos;
  arb_state_e  dbg_state;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
    .clock(clock), .resetn(resetn),
    .pipe_we(pipe_we), .pipe_pos(pipe_pos), .pipe_value(pipe_value),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_pos(mdu_pos), .mdu_value(mdu_value),
    .wr_pos(wr_pos), .wr_value(wr_value), .stall_pipe(stall_pipe),
    .pend_valid(pend_valid), .pend_pos(pend_pos), .drop_pulse(drop_pulse),
    .protocol_err(protocol_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  function automatic logic [EXP_W-1:0] pack(input logic [4:0] wp, input logic [31:0] wv,
                                            input logic rdy, input logic st, input logic pv,
                                            input logic [4:0] pp, input logic dr, input logic pe);
    return {wp, wv, rdy, st, pv, pp, dr, pe};
  endfunction

  task automatic check_outputs(input string name);
    logic [EXP_W-1:0] exp_v, act_v;
    act_v = pack(wr_pos, wr_value, mdu_ready, stall_pipe, pend_valid, pend_pos,
                 drop_pulse, protocol_err);
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, actual=%h", name, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v === exp_v) passed++;
      else $display("FAIL %s: actual {wpos,wval,rdy,stall,pv,ppos,drop,perr}=%h required=%h",
                    name, act_v, exp_v);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp_b);
    checks++;
    if (act === exp_b) passed++;
    else $display("FAIL %s: actual=%b required=%b", name, act, exp_b);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic pwe, input logic [4:0] ppos, input logic [31:0] pval,
                       input logic mv, input logic [4:0] mpos, input logic [31:0] mval);
    pipe_we    = pwe;
    pipe_pos   = ppos;
    pipe_value = pval;
    mdu_valid  = mv;
    mdu_pos    = mpos;
    mdu_value  = mval;
  endtask

  typedef struct {
    string       name;
    logic        pwe;
    logic [4:0]  ppos;
    logic [31:0] pval;
    logic        mv;
    logic [4:0]  mpos;
    logic [31:0] mval;
    logic [4:0]  e_wpos;
    logic [31:0] e_wval;
    logic        e_rdy, e_stall, e_pv;
    logic [4:0]  e_ppos;
    logic        e_drop, e_perr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic pwe, input logic [4:0] ppos, input logic [31:0] pval,
                     input logic mv, input logic [4:0] mpos, input logic [31:0] mval,
                     input logic [4:0] ewp, input logic [31:0] ewv, input logic rdy, input logic st,
                     input logic pv, input logic [4:0] epp, input logic dr, input logic pe);
    vec_t v;
    v.name = n; v.pwe = pwe; v.ppos = ppos; v.pval = pval;
    v.mv = mv; v.mpos = mpos; v.mval = mval;
    v.e_wpos = ewp; v.e_wval = ewv; v.e_rdy = rdy; v.e_stall = st; v.e_pv = pv;
    v.e_ppos = epp; v.e_drop = dr; v.e_perr = pe;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs for one cycle, then outputs expected within that cycle
    //      name          pwe ppos pval     mv mpos mval         wpos wval      rdy st pv pp dr pe
    add("t1_pipe",        1, 5,  32'd54,  0, 0,  32'h0,      5,  32'd54,   1, 0, 0, 0, 0, 0);
    add("t1_idle",        0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t2_accept",      0, 0,  32'h0,   1, 7,  32'h1234,   0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t2_write",       0, 0,  32'h0,   1, 9,  32'h999,    7,  32'h1234, 0, 0, 1, 7, 0, 0);
    add("t2_ready",       0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t3_accept",      0, 0,  32'h0,   1, 8,  32'h88,     0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t3_wait1",       1, 9,  32'h901, 0, 0,  32'h0,      9,  32'h901,  0, 0, 1, 8, 0, 0);
    add("t3_wait2",       1, 9,  32'h902, 0, 0,  32'h0,      9,  32'h902,  0, 0, 1, 8, 0, 0);
    add("t3_wait3",       1, 9,  32'h903, 0, 0,  32'h0,      9,  32'h903,  0, 0, 1, 8, 0, 0);
    add("t4_force_wr",    0, 0,  32'h0,   0, 0,  32'h0,      8,  32'h88,   0, 1, 1, 8, 0, 0);
    add("t4_after",       0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("mdu_r0",         0, 0,  32'h0,   1, 0,  32'hdead,   0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("mdu_r0_gone",    0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("pipe0_accept",   0, 0,  32'h0,   1, 12, 32'hc,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("pipe0_frees",    1, 0,  32'hffff,0, 0,  32'h0,      12, 32'hc,    0, 0, 1, 12,0, 0);
    add("pipe0_after",    0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t5_accept",      0, 0,  32'h0,   1, 3,  32'h333,    0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t5_drop",        1, 3,  32'h3a,  0, 0,  32'h0,      3,  32'h3a,   0, 0, 1, 3, 1, 0);
    add("t5_after",       0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("fdrop_accept",   0, 0,  32'h0,   1, 4,  32'h44,     0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("fdrop_w1",       1, 5,  32'h51,  0, 0,  32'h0,      5,  32'h51,   0, 0, 1, 4, 0, 0);
    add("fdrop_w2",       1, 5,  32'h52,  0, 0,  32'h0,      5,  32'h52,   0, 0, 1, 4, 0, 0);
    add("fdrop_w3",       1, 5,  32'h53,  0, 0,  32'h0,      5,  32'h53,   0, 0, 1, 4, 0, 0);
    add("fdrop_drop",     1, 4,  32'h4b,  0, 0,  32'h0,      4,  32'h4b,   0, 1, 1, 4, 1, 0);
    add("fdrop_after",    0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t6_accept",      0, 0,  32'h0,   1, 6,  32'h66,     0,  32'h0,    1, 0, 0, 0, 0, 0);
    add("t6_w1",          1, 11, 32'hb1,  0, 0,  32'h0,      11, 32'hb1,   0, 0, 1, 6, 0, 0);
    add("t6_w2",          1, 11, 32'hb2,  0, 0,  32'h0,      11, 32'hb2,   0, 0, 1, 6, 0, 0);
    add("t6_w3",          1, 11, 32'hb3,  0, 0,  32'h0,      11, 32'hb3,   0, 0, 1, 6, 0, 0);
    add("t6_viol1",       1, 10, 32'ha0,  0, 0,  32'h0,      10, 32'ha0,   0, 1, 1, 6, 0, 0);
    add("t6_viol2",       1, 10, 32'ha1,  0, 0,  32'h0,      10, 32'ha1,   0, 1, 1, 6, 0, 1);
    add("t6_grant",       0, 0,  32'h0,   0, 0,  32'h0,      6,  32'h66,   0, 1, 1, 6, 0, 1);
    add("t6_sticky",      0, 0,  32'h0,   0, 0,  32'h0,      0,  32'h0,    1, 0, 0, 0, 0, 1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        r_we;
    logic [4:0]  r_pos;
    logic [31:0] r_val;
    logic        r_eff;

    // Reset: state outputs idle, write port still follows the pipe
    drive(1, 4, 32'h77, 0, 0, 0);
    #2;
    exp_q.push_back(pack(4, 32'h77, 1, 0, 0, 0, 0, 0));
    check_outputs("reset_pipe_passthru");
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, 0));
    check_outputs("reset_state");
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].pwe, vecs[i].ppos, vecs[i].pval, vecs[i].mv, vecs[i].mpos, vecs[i].mval);
      exp_q.push_back(pack(vecs[i].e_wpos, vecs[i].e_wval, vecs[i].e_rdy, vecs[i].e_stall,
                           vecs[i].e_pv, vecs[i].e_ppos, vecs[i].e_drop, vecs[i].e_perr));
      #2;
      check_outputs(vecs[i].name);
      if (vecs[i].name == "t5_after")
        check_bit("t5_state_empty", dbg_state == ST_EMPTY, 1'b1);
    end

    // Reset asserted mid-HELD discards the buffer and clears the sticky error
    @(negedge clock);
    drive(0, 0, 0, 1, 2, 32'h22);
    @(negedge clock);
    drive(1, 1, 32'h11, 0, 0, 0);
    #2;
    exp_q.push_back(pack(1, 32'h11, 0, 0, 1, 2, 0, 1));
    check_outputs("rst_mid_held");
    resetn = 1'b0;
    #1;
    exp_q.push_back(pack(1, 32'h11, 1, 0, 0, 0, 0, 0));
    check_outputs("rst_async_clear");
    @(negedge clock);
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, 0));
    check_outputs("rst_buffer_discarded");

    // Randomized pipeline-only traffic against a stateless model
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      r_we  = 1'($urandom_range(0, 1));
      r_pos = 5'($urandom_range(0, 31));
      if (i % 6 == 0) r_pos = 5'd0;
      r_val = $urandom();
      drive(r_we, r_pos, r_val, 0, 0, 0);
      r_eff = r_we && (r_pos != 5'd0);
      exp_q.push_back(pack(r_eff ? r_pos : 5'd0, r_eff ? r_val : 32'h0, 1, 0, 0, 0, 0, 0));
      #2;
      check_outputs($sformatf("rand_pipe_%0d", i));
    end

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: actual=%0d entries left required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, actual=%0d checks required=done", checks);
    $fatal(1, "timeout");
  end

endmodule
